memory_cycle: RTL and testbench
===============================

Name: memory_cycle

Overview:
- Fourth stage (MEM) of the 5-stage RISC-V pipeline.
- Consumes the execute-stage EX/MEM outputs (RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM, PCPlus4M).
- Performs the data-memory access against an internal word-addressed RAM.
- Registers everything into the MEM/WB pipeline register that feeds writeback_cycle.

Parameters:
- DMEM_DEPTH, 1024, number of 32-bit words in data memory (power of two).
- DMEM_AW, 10, word-address width; must equal log2(DMEM_DEPTH).

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- StallM  in  1  hold MEM/WB register, suppress store.
- FlushM  in  1  insert bubble into MEM/WB, suppress store.
- RegWriteM  in  1  register-file write enable from EX/MEM.
- ResultSrcM  in  1  0 = ALU result, 1 = load data.
- MemWriteM  in  1  store enable.
- ALUResultM  in  32  byte address / ALU result.
- WriteDataM  in  32  store data.
- RdM  in  5  destination register.
- PCPlus4M  in  32  PC+4 passthrough.
- RegWriteW  out  1  registered RegWriteM.
- ResultSrcW  out  1  registered ResultSrcM.
- ReadDataW  out  32  registered load data.
- ALUResultW  out  32  registered ALUResultM.
- RdW  out  5  registered RdM.
- PCPlus4W  out  32  registered PCPlus4M.
- MisalignW  out  1  sticky misalignment flag (only with optional feature, else tied 0).

Behaviour:
- Reset:
  - rst high asynchronously clears all W outputs to 0, and MisalignW to 0.
  - Data-memory contents are NOT reset; they retain their value across rst.
- Addressing:
  - Word index = ALUResultM[DMEM_AW+1:2].
  - Bits [1:0] and bits above DMEM_AW+1 are ignored, so addresses wrap modulo DMEM_DEPTH*4.
- Read path:
  - Combinational read of mem[index] every cycle, captured into ReadDataW at the rising edge.
  - Load-to-W latency is 1 cycle.
- Write path:
  - mem[index] <= WriteDataM on the rising edge when MemWriteM=1, StallM=0, FlushM=0 and rst=0.
  - Full word only.
- Read-during-write, same index, same edge: ReadDataW captures the OLD contents (read-before-write).
- Pipeline register priority is rst > FlushM > StallM > normal load:
  - FlushM=1: RegWriteW=0, ResultSrcW=0, RdW=0, other W fields 0; no store.
  - StallM=1 (FlushM=0): all W outputs hold; no store.
  - Normal: all W outputs load their M counterparts.
- rst asserted mid-store: the store at that edge is dropped and the memory word keeps its prior value.
- No internal FSM beyond the pipeline register. The stall/flush control is the only sequencing.

Optional Feature:
- Macro MISALIGN_CHECK_EN.
- Defined:
  - If MemWriteM=1 or ResultSrcM=1, and ALUResultM[1:0]!=0, the store is suppressed and MisalignW sets on that edge.
  - MisalignW is sticky until rst; the RegWrite of a misaligned load is forced 0 in W.
- Undefined: no check, bits [1:0] silently ignored, MisalignW tied 0.

Decomposition:
- Shared package riscv_pkg:
  - XLEN=32, REG_AW=5
  - ResultSrc encodings RES_ALU=0, RES_MEM=1
  - NOP/bubble constants for the MEM/WB record
- One sub-module, data_memory: single-port synchronous-write, asynchronous-read RAM with ports clk, we, addr[DMEM_AW-1:0], wd[31:0], rd[31:0].
- The MEM/WB register stays in memory_cycle.

Test Plan:
- Reset:
  - Pulse rst high mid-cycle -> all W outputs 0 immediately, without waiting for a clock edge.
  - After release, the first edge loads the M inputs.
- Store then load:
  - Edge 1: MemWriteM=1, ALUResultM=0x10, WriteDataM=0x6969ABCD.
  - Edge 2: MemWriteM=0, ResultSrcM=1, RegWriteM=1, RdM=5.
  - Required: after edge 2, ReadDataW=0x6969ABCD, RdW=5, ResultSrcW=1.
- Read-during-write:
  - mem[4]=0x1234, then store 0x4321 to 0x10 with ResultSrcM=1 on the same edge.
  - Required: ReadDataW=0x1234; the next load returns 0x4321.
- Stall/flush:
  - StallM=1 with MemWriteM=1 for 2 edges -> W outputs frozen, memory unchanged.
  - FlushM=1 -> RegWriteW=0, RdW=0.
  - FlushM and StallM both 1 -> flush wins.
- Wrap:
  - Store 0xDEADBEEF at address 4096+8 with DMEM_DEPTH=1024.
  - Required: a load from 0x8 returns 0xDEADBEEF.
- With MISALIGN_CHECK_EN:
  - Store to 0x13 -> memory unchanged, MisalignW=1, held until rst.
  - Without the macro: same stimulus writes word 4, MisalignW=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline.
// Provides the datapath widths, the ResultSrc encodings and the MEM/WB pipeline
// record together with its bubble value.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    // ResultSrc encodings: which value writeback returns to the register file.
    localparam logic RES_ALU = 1'b0;
    localparam logic RES_MEM = 1'b1;

    // Contents of the MEM/WB pipeline register.
    typedef struct packed {
        logic              reg_write;
        logic              result_src;
        logic [XLEN-1:0]   read_data;
        logic [XLEN-1:0]   alu_result;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   pc_plus4;
    } memwb_t;

    // Bubble: no register write, all fields zero.
    localparam memwb_t MEMWB_NOP = '0;

endpackage

// File: rtl/data_memory.sv
// Data memory for the MEM stage.
// Single-port RAM of DMEM_DEPTH 32-bit words: synchronous write on the rising edge,
// asynchronous (combinational) read. Contents are not reset.
// Ports:
//   clk  - write clock
//   we   - write enable, full word
//   addr - word index
//   wd   - write data
//   rd   - read data, combinational from addr
module data_memory #(
    parameter int unsigned DMEM_DEPTH = 1024,
    parameter int unsigned DMEM_AW    = 10
) (
    input  logic               clk,
    input  logic               we,
    input  logic [DMEM_AW-1:0] addr,
    input  logic [31:0]        wd,
    output logic [31:0]        rd
);

    logic [31:0] mem [DMEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wd;
        end
    end

    // Read sees the pre-edge contents, so a same-edge write is read-before-write.
    assign rd = mem[addr];

endmodule

// File: rtl/memory_cycle.sv
// MEM stage of the 5-stage RISC-V pipeline.
// Performs the data-memory access for the instruction in EX/MEM and registers the
// result into the MEM/WB pipeline register feeding writeback_cycle.
// Optional feature macro: MISALIGN_CHECK_EN -- when defined, loads/stores with a
// non-zero ALUResultM[1:0] suppress the store, drop the load's register write and set
// the sticky MisalignW flag; when undefined MisalignW is tied 0.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   StallM, FlushM      - hold / bubble the MEM/WB register (both suppress the store)
//   RegWriteM .. PCPlus4M - EX/MEM inputs
//   RegWriteW .. PCPlus4W - MEM/WB outputs
//   MisalignW           - sticky misalignment flag
module memory_cycle
    import riscv_pkg::*;
#(
    parameter int unsigned DMEM_DEPTH = 1024,
    parameter int unsigned DMEM_AW    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallM,
    input  logic              FlushM,
    input  logic              RegWriteM,
    input  logic              ResultSrcM,
    input  logic              MemWriteM,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [XLEN-1:0]   WriteDataM,
    input  logic [REG_AW-1:0] RdM,
    input  logic [XLEN-1:0]   PCPlus4M,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [XLEN-1:0]   ReadDataW,
    output logic [XLEN-1:0]   ALUResultW,
    output logic [REG_AW-1:0] RdW,
    output logic [XLEN-1:0]   PCPlus4W,
    output logic              MisalignW
);

    logic [DMEM_AW-1:0] word_idx;
    logic [XLEN-1:0]    read_data;
    logic               misalign;
    logic               advance;
    logic               store_en;
    memwb_t             memwb_d, memwb_q;

    // Byte offset and bits beyond the memory size are dropped, so addresses wrap.
    assign word_idx = ALUResultM[DMEM_AW+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ALUResultM[XLEN-1:DMEM_AW+2], ALUResultM[1:0]};

`ifdef MISALIGN_CHECK_EN
    assign misalign = (MemWriteM | (ResultSrcM == RES_MEM)) & (ALUResultM[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // The instruction moves into W only when neither flushed nor stalled.
    assign advance  = ~FlushM & ~StallM;
    // rst gating drops a store coinciding with a reset edge.
    assign store_en = MemWriteM & advance & ~rst & ~misalign;

    data_memory #(
        .DMEM_DEPTH (DMEM_DEPTH),
        .DMEM_AW    (DMEM_AW)
    ) u_data_memory (
        .clk  (clk),
        .we   (store_en),
        .addr (word_idx),
        .wd   (WriteDataM),
        .rd   (read_data)
    );

    // Priority: flush over stall over normal load.
    always_comb begin
        memwb_d = memwb_q;
        if (FlushM) begin
            memwb_d = MEMWB_NOP;
        end else if (!StallM) begin
            memwb_d.reg_write  = RegWriteM & ~(misalign & (ResultSrcM == RES_MEM));
            memwb_d.result_src = ResultSrcM;
            memwb_d.read_data  = read_data;
            memwb_d.alu_result = ALUResultM;
            memwb_d.rd         = RdM;
            memwb_d.pc_plus4   = PCPlus4M;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memwb_q <= MEMWB_NOP;
        end else begin
            memwb_q <= memwb_d;
        end
    end

    assign RegWriteW  = memwb_q.reg_write;
    assign ResultSrcW = memwb_q.result_src;
    assign ReadDataW  = memwb_q.read_data;
    assign ALUResultW = memwb_q.alu_result;
    assign RdW        = memwb_q.rd;
    assign PCPlus4W   = memwb_q.pc_plus4;

`ifdef MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (misalign && advance) begin
            misalign_q <= 1'b1;
        end
    end

    assign MisalignW = misalign_q;
`else
    assign MisalignW = 1'b0;
`endif

endmodule

// File: tb/tb_memory_cycle.sv
module tb_memory_cycle;

    localparam int unsigned DEPTH = 1024;
`ifdef MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_m, flush_m, reg_write_m, result_src_m, mem_write_m;
    logic [31:0] alu_m, wd_m, pc_m;
    logic [4:0]  rd_m;
    logic        reg_write_w, result_src_w, misalign_w;
    logic [31:0] read_data_w, alu_w, pc_w;
    logic [4:0]  rd_w;

    // Reference model: memory contents and expected W outputs.
    logic [31:0] ref_mem [DEPTH];
    logic        e_rw, e_rs, e_mis;
    logic [31:0] e_rdata, e_alu, e_pc;
    logic [4:0]  e_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memory_cycle #(
        .DMEM_DEPTH (1024),
        .DMEM_AW    (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .StallM     (stall_m),
        .FlushM     (flush_m),
        .RegWriteM  (reg_write_m),
        .ResultSrcM (result_src_m),
        .MemWriteM  (mem_write_m),
        .ALUResultM (alu_m),
        .WriteDataM (wd_m),
        .RdM        (rd_m),
        .PCPlus4M   (pc_m),
        .RegWriteW  (reg_write_w),
        .ResultSrcW (result_src_w),
        .ReadDataW  (read_data_w),
        .ALUResultW (alu_w),
        .RdW        (rd_w),
        .PCPlus4W   (pc_w),
        .MisalignW  (misalign_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".RegWriteW"},  {31'd0, reg_write_w},  {31'd0, e_rw});
        check({ctx, ".ResultSrcW"}, {31'd0, result_src_w}, {31'd0, e_rs});
        check({ctx, ".ReadDataW"},  read_data_w, e_rdata);
        check({ctx, ".ALUResultW"}, alu_w, e_alu);
        check({ctx, ".RdW"},        {27'd0, rd_w}, {27'd0, e_rd});
        check({ctx, ".PCPlus4W"},   pc_w, e_pc);
        check({ctx, ".MisalignW"},  {31'd0, misalign_w}, {31'd0, e_mis});
    endtask

    task automatic model_clear();
        e_rw = 0; e_rs = 0; e_rdata = 0; e_alu = 0; e_rd = 0; e_pc = 0; e_mis = 0;
    endtask

    task automatic drive(input bit mw, input bit rs, input bit rw, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input bit st,
                         input bit fl);
        mem_write_m = mw; result_src_m = rs; reg_write_m = rw; alu_m = a; wd_m = wd;
        rd_m = rd; stall_m = st; flush_m = fl; pc_m = $urandom;
    endtask

    // Predict one clock edge from the current inputs, then compare after it.
    task automatic tick(input string ctx);
        int unsigned idx;
        bit          mis;
        logic [31:0] old;
        logic [1:0]  off;
        idx = (alu_m / 4) % DEPTH;
        off = alu_m[1:0];
        mis = MIS_EN && (mem_write_m || result_src_m) && off != 2'b00;
        old = ref_mem[idx];
        if (flush_m) begin
            e_rw = 0; e_rs = 0; e_rdata = 0; e_alu = 0; e_rd = 0; e_pc = 0;
        end else if (!stall_m) begin
            e_rw = reg_write_m && !(mis && result_src_m);
            e_rs = result_src_m; e_rdata = old; e_alu = alu_m; e_rd = rd_m; e_pc = pc_m;
            if (mis) e_mis = 1;
        end
        if (mem_write_m && !stall_m && !flush_m && !mis) ref_mem[idx] = wd_m;
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    // Asynchronous reset pulse starting mid-cycle, held across one edge carrying a store.
    task automatic reset_pulse(input logic [31:0] a, input logic [31:0] wd);
        drive(1, 0, 1, a, wd, 5'd3, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
        model_clear();
        #3;
        check_all("reset");
        #4;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill memory with known random contents.
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1, 0, 0, 32'(i * 4), $urandom, 5'd0, 0, 0);
            tick("init");
        end

        // Store then load.
        drive(1, 0, 0, 32'h10, 32'h6969ABCD, 5'd0, 0, 0);
        tick("store");
        drive(0, 1, 1, 32'h10, 32'h0, 5'd5, 0, 0);
        tick("load");
        check("load_const", read_data_w, 32'h6969ABCD);

        // Read-during-write.
        drive(1, 0, 0, 32'h10, 32'h1234, 5'd0, 0, 0);
        tick("rdw_setup");
        drive(1, 1, 1, 32'h10, 32'h4321, 5'd7, 0, 0);
        tick("rdw");
        check("rdw_old", read_data_w, 32'h1234);
        drive(0, 1, 1, 32'h10, 32'h0, 5'd7, 0, 0);
        tick("rdw_new");
        check("rdw_new_const", read_data_w, 32'h4321);

        // Stall for two edges with a store pending, then verify memory untouched.
        drive(1, 1, 1, 32'h20, 32'hCAFEF00D, 5'd9, 1, 0);
        tick("stall1");
        tick("stall2");
        drive(0, 1, 1, 32'h20, 32'h0, 5'd9, 0, 0);
        tick("after_stall");

        // Flush, then flush+stall.
        drive(1, 1, 1, 32'h24, 32'h11111111, 5'd12, 0, 1);
        tick("flush");
        drive(0, 1, 1, 32'h24, 32'h0, 5'd12, 0, 0);
        tick("post_flush");
        drive(1, 1, 1, 32'h28, 32'h22222222, 5'd13, 1, 1);
        tick("flush_stall");
        check("flush_stall_rd", {27'd0, rd_w}, 32'd0);

        // Address wrap.
        drive(1, 0, 0, 32'd4096 + 32'd8, 32'hDEADBEEF, 5'd0, 0, 0);
        tick("wrap_store");
        drive(0, 1, 1, 32'h8, 32'h0, 5'd1, 0, 0);
        tick("wrap_load");
        check("wrap_const", read_data_w, 32'hDEADBEEF);

        // Misaligned store to 0x13, then read word 4 back.
        drive(1, 0, 0, 32'h13, 32'hA5A5A5A5, 5'd0, 0, 0);
        tick("mis_store");
        drive(0, 0, 1, 32'h10, 32'h0, 5'd2, 0, 0);
        tick("mis_hold");
        drive(0, 1, 1, 32'h10, 32'h0, 5'd2, 0, 0);
        tick("mis_read");

        // Mid-cycle reset with a store on the reset edge; memory must be unchanged.
        reset_pulse(32'h10, 32'h0BADF00D);
        drive(0, 1, 1, 32'h10, 32'h0, 5'd4, 0, 0);
        tick("post_rst_load");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = $urandom & 32'hFFFF_F03F;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 49) == 0) begin
                reset_pulse(a, $urandom);
            end else begin
                drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, a, $urandom, 5'($urandom),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
                tick("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
